// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit
// Instruction fetch front end: walks a word-addressed PC, issues one
// outstanding instruction-memory read at a time, and buffers returned words
// with their PCs in a 2-entry FIFO for decode. Branch redirects flush the
// buffer; a request already on the bus when a redirect lands is allowed to
// finish and its data is thrown away.
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc_in,
  input  logic        redirect,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic [31:0] pc_plus1,
  input  logic        inst_ready
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FULL  = 2'd2,
    S_DROP  = 2'd3
  } state_t;

  state_t      state;

  // fetch_pc is always the address on the bus. While a stale request drains
  // in S_DROP, the redirect target waits in pend_pc so the bus stays stable.
  logic [31:0] fetch_pc;
  logic [31:0] pend_pc;

  logic [31:0] fifo_word [2];
  logic [31:0] fifo_pc   [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic [1:0]  count_next;

  logic        flush;
  logic        push;
  logic        pop;

  // A redirect is ignored only in S_IDLE; it also cancels any pop that cycle.
  assign flush = redirect && (state != S_IDLE);
  assign pop   = inst_valid && inst_ready && !flush;
  assign push  = (state == S_FETCH) && imem_ack && !flush;

  assign imem_addr  = fetch_pc;
  assign inst_valid = (count != 2'd0);
  assign inst_out   = fifo_word[rd_ptr];
  assign inst_pc    = fifo_pc[rd_ptr];
  assign pc_plus1   = inst_pc + 32'd1;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    // NOTE: default assignment first so every path drives count_next and no latch is inferred.
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  // Fetch control FSM: state, registered request strobe and PC bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state    <= S_IDLE;
      imem_req <= 1'b0;
      fetch_pc <= RESET_PC;
      pend_pc  <= RESET_PC;
    end else begin
      unique case (state)
        S_IDLE: begin
          state    <= S_FETCH;
          imem_req <= 1'b1;
        end

        S_FETCH: begin
          if (redirect) begin
            if (imem_ack) begin
              // Returning word belongs to the wrong path: drop it, refetch now.
              fetch_pc <= next_pc_in;
            end else begin
              // Request in flight: let it finish on the old address.
              pend_pc <= next_pc_in;
              state   <= S_DROP;
            end
          end else if (imem_ack) begin
            fetch_pc <= fetch_pc + 32'd1;
            if (count_next == 2'd2) begin
              state    <= S_FULL;
              imem_req <= 1'b0;
            end
          end
        end

        S_FULL: begin
          if (redirect) begin
            fetch_pc <= next_pc_in;
            state    <= S_FETCH;
            imem_req <= 1'b1;
          end else if (pop) begin
            state    <= S_FETCH;
            imem_req <= 1'b1;
          end
        end

        S_DROP: begin
          if (redirect) begin
            pend_pc <= next_pc_in;
          end
          if (imem_ack) begin
            fetch_pc <= redirect ? next_pc_in : pend_pc;
            state    <= S_FETCH;
          end
        end

        default: begin
          state    <= S_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  // Instruction FIFO: two {word, pc} slots with wrap-around pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the storage is reset too because the head must read as zero during reset; at two entries this is cheap.
    if (!rst_n) begin
      count        <= 2'd0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      fifo_word[0] <= 32'd0;
      fifo_word[1] <= 32'd0;
      fifo_pc[0]   <= 32'd0;
      fifo_pc[1]   <= 32'd0;
    end else if (flush) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) begin
        fifo_word[wr_ptr] <= imem_rdata;
        fifo_pc[wr_ptr]   <= fetch_pc;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count_next;
    end
  end

  // S_FETCH is only ever entered with a free slot, so a push never meets a full FIFO.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && (count == 2'd2)));

endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb_mips_fetch_unit
// Self-checking bench for mips_fetch_unit. A behavioural instruction memory
// answers requests after a programmable number of wait cycles; expected
// {pc, word} pairs are queued as stimulus is planned and compared whenever
// decode accepts the head instruction. A second instance with an all-ones
// reset PC covers the address wrap.
module tb_mips_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] next_pc_in;
  logic        redirect;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic [31:0] pc_plus1;
  logic        inst_ready;

  // Wrap-test instance: own memory port, always ready, never redirected.
  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic        imem_ack2;
  logic [31:0] imem_rdata2;
  logic        inst_valid2;
  logic [31:0] inst_out2;
  logic [31:0] inst_pc2;
  logic [31:0] pc_plus1_2;
  logic        redirect2;
  logic [31:0] next_pc2;
  logic        inst_ready2;

  int   checks;
  int   errors;
  int   mem_wait;
  int   wait_cnt;
  exp_t exp_q[$];

  mips_fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .next_pc_in (next_pc_in),
    .redirect   (redirect),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst_out   (inst_out),
    .inst_pc    (inst_pc),
    .pc_plus1   (pc_plus1),
    .inst_ready (inst_ready)
  );

  mips_fetch_unit #(.RESET_PC(32'hFFFF_FFFF)) dut_wrap (
    .clk        (clk),
    .rst_n      (rst_n),
    .next_pc_in (next_pc2),
    .redirect   (redirect2),
    .imem_req   (imem_req2),
    .imem_addr  (imem_addr2),
    .imem_ack   (imem_ack2),
    .imem_rdata (imem_rdata2),
    .inst_valid (inst_valid2),
    .inst_out   (inst_out2),
    .inst_pc    (inst_pc2),
    .pc_plus1   (pc_plus1_2),
    .inst_ready (inst_ready2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a ^ 32'h5A5A_0000) + 32'h0000_1111;
  endfunction

  function automatic exp_t mk(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.word = word_of(pc);
    return e;
  endfunction

  // One clock: at the falling edge the memory model answers and the
  // scoreboard checks any accepted instruction; returns 1 ns after the rise.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (imem_req && rst_n) begin
      if (wait_cnt >= mem_wait) begin
        imem_ack   = 1'b1;
        imem_rdata = word_of(imem_addr);
        wait_cnt   = 0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 32'h0BAD_0BAD;
        wait_cnt   = wait_cnt + 1;
      end
    end else begin
      imem_ack = 1'b0;
      wait_cnt = 0;
    end
    imem_ack2   = imem_req2 && rst_n;
    imem_rdata2 = word_of(imem_addr2);
    if (inst_valid && inst_ready && !redirect) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got pc %h word %h, want no instruction", inst_pc, inst_out);
      end else begin
        e = exp_q.pop_front();
        if (inst_pc !== e.pc || inst_out !== e.word || pc_plus1 !== e.pc + 32'd1) begin
          errors++;
          $display("FAIL sb_inst: got pc %h word %h plus1 %h, want pc %h word %h plus1 %h",
                   inst_pc, inst_out, pc_plus1, e.pc, e.word, e.pc + 32'd1);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Reset both instances, release away from the edge, and step past S_IDLE.
  task automatic apply_reset();
    rst_n      = 1'b0;
    imem_ack   = 1'b0;
    imem_ack2  = 1'b0;
    redirect   = 1'b0;
    next_pc_in = 32'd0;
    inst_ready = 1'b0;
    mem_wait   = 0;
    wait_cnt   = 0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    redirect   = 1'b0;
    next_pc_in = 32'd0;
    inst_ready = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    imem_ack2  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
    checks++; if (imem_addr !== 32'd0) begin errors++; $display("FAIL reset_addr: got %h want 00000000", imem_addr); end
    checks++; if (inst_out !== 32'd0) begin errors++; $display("FAIL reset_inst_out: got %h want 00000000", inst_out); end
    checks++; if (inst_pc !== 32'd0) begin errors++; $display("FAIL reset_inst_pc: got %h want 00000000", inst_pc); end
    checks++; if (pc_plus1 !== 32'd1) begin errors++; $display("FAIL reset_pc_plus1: got %h want 00000001", pc_plus1); end
    checks++; if (imem_addr2 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_addr_wrap: got %h want ffffffff", imem_addr2); end
    // Release with ack still high: the S_IDLE edge must ignore it.
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL idle_ack_ignored: got valid %b want 0", inst_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin errors++; $display("FAIL first_req: got req %b addr %h want 1 00000000", imem_req, imem_addr); end
  endtask

  task automatic test_stream();
    apply_reset();
    inst_ready = 1'b1;
    for (int i = 0; i < 6; i++) exp_q.push_back(mk(i));
    cycle();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== i || imem_addr !== i + 1) begin
        errors++;
        $display("FAIL stream_head_%0d: got valid %b pc %h addr %h want 1 %h %h", i, inst_valid, inst_pc, imem_addr, i, i + 1);
      end
      cycle();
    end
    inst_ready = 1'b0;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stream_drain: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    cycle();
    cycle();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== 32'd0 || imem_addr !== 32'd2) begin
        errors++;
        $display("FAIL full_hold_%0d: got req %b valid %b pc %h addr %h want 0 1 0 2", i, imem_req, inst_valid, inst_pc, imem_addr);
      end
      cycle();
    end
    exp_q.push_back(mk(0));
    exp_q.push_back(mk(1));
    exp_q.push_back(mk(2));
    inst_ready = 1'b1;
    cycle();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd2 || inst_pc !== 32'd1) begin
      errors++;
      $display("FAIL full_resume: got req %b addr %h pc %h want 1 2 1", imem_req, imem_addr, inst_pc);
    end
    cycle();
    cycle();
    inst_ready = 1'b0;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL full_drain: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_drop();
    apply_reset();
    inst_ready = 1'b1;
    for (int i = 0; i < 5; i++) exp_q.push_back(mk(i));
    for (int i = 0; i < 5; i++) cycle();
    mem_wait = 3;
    cycle();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd5 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_pending: got req %b addr %h valid %b want 1 5 0", imem_req, imem_addr, inst_valid);
    end
    redirect   = 1'b1;
    next_pc_in = 32'h30;
    cycle();
    checks++; if (imem_addr !== 32'd5 || imem_req !== 1'b1) begin errors++; $display("FAIL drop_hold1: got req %b addr %h want 1 5", imem_req, imem_addr); end
    next_pc_in = 32'h40;
    cycle();
    redirect = 1'b0;
    checks++; if (imem_addr !== 32'd5 || imem_req !== 1'b1) begin errors++; $display("FAIL drop_hold2: got req %b addr %h want 1 5", imem_req, imem_addr); end
    cycle();
    checks++;
    if (imem_addr !== 32'h40 || imem_req !== 1'b1 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_retarget: got req %b addr %h valid %b want 1 40 0", imem_req, imem_addr, inst_valid);
    end
    mem_wait = 0;
    exp_q.push_back(mk(32'h40));
    exp_q.push_back(mk(32'h41));
    cycle();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h40) begin errors++; $display("FAIL drop_first: got valid %b pc %h want 1 40", inst_valid, inst_pc); end
    cycle();
    cycle();
    inst_ready = 1'b0;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL drop_drain: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_redirect_ack();
    apply_reset();
    inst_ready = 1'b1;
    cycle();
    redirect   = 1'b1;
    next_pc_in = 32'h200;
    cycle();
    redirect = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || imem_addr !== 32'h200 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL redir_ack: got valid %b addr %h req %b want 0 200 1", inst_valid, imem_addr, imem_req);
    end
    exp_q.push_back(mk(32'h200));
    exp_q.push_back(mk(32'h201));
    cycle();
    cycle();
    cycle();
    inst_ready = 1'b0;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL redir_ack_drain: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_full_redirect();
    apply_reset();
    inst_ready = 1'b1;
    for (int i = 0; i < 7; i++) exp_q.push_back(mk(i));
    for (int i = 0; i < 8; i++) cycle();
    inst_ready = 1'b0;
    cycle();
    checks++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== 32'd7 || imem_addr !== 32'd9) begin
      errors++;
      $display("FAIL full78: got req %b valid %b pc %h addr %h want 0 1 7 9", imem_req, inst_valid, inst_pc, imem_addr);
    end
    inst_ready = 1'b1;
    redirect   = 1'b1;
    next_pc_in = 32'h100;
    cycle();
    redirect = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || imem_addr !== 32'h100 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL full_flush: got valid %b addr %h req %b want 0 100 1", inst_valid, imem_addr, imem_req);
    end
    exp_q.push_back(mk(32'h100));
    cycle();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100) begin errors++; $display("FAIL full_refetch: got valid %b pc %h want 1 100", inst_valid, inst_pc); end
    inst_ready = 1'b1;
    cycle();
    inst_ready = 1'b0;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL full_redir_drain: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    apply_reset();
    checks++; if (imem_addr2 !== 32'hFFFF_FFFF || imem_req2 !== 1'b1) begin errors++; $display("FAIL wrap_req: got req %b addr %h want 1 ffffffff", imem_req2, imem_addr2); end
    cycle();
    checks++;
    if (inst_valid2 !== 1'b1 || inst_pc2 !== 32'hFFFF_FFFF || pc_plus1_2 !== 32'd0 || inst_out2 !== word_of(32'hFFFF_FFFF)) begin
      errors++;
      $display("FAIL wrap_first: got valid %b pc %h plus1 %h word %h want 1 ffffffff 00000000 %h",
               inst_valid2, inst_pc2, pc_plus1_2, inst_out2, word_of(32'hFFFF_FFFF));
    end
    checks++; if (imem_addr2 !== 32'd0) begin errors++; $display("FAIL wrap_addr: got %h want 00000000", imem_addr2); end
    cycle();
    checks++;
    if (inst_valid2 !== 1'b1 || inst_pc2 !== 32'd0 || pc_plus1_2 !== 32'd1) begin
      errors++;
      $display("FAIL wrap_second: got valid %b pc %h plus1 %h want 1 00000000 00000001", inst_valid2, inst_pc2, pc_plus1_2);
    end
  endtask

  task automatic test_reset_in_drop();
    apply_reset();
    mem_wait = 5;
    cycle();
    redirect   = 1'b1;
    next_pc_in = 32'h55;
    cycle();
    redirect = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin errors++; $display("FAIL rdrop_pending: got req %b addr %h want 1 0", imem_req, imem_addr); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0 || imem_addr !== 32'd0) begin
      errors++;
      $display("FAIL rdrop_async: got req %b valid %b addr %h want 0 0 0", imem_req, inst_valid, imem_addr);
    end
    imem_ack = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    imem_ack = 1'b0;
    wait_cnt = 0;
    mem_wait = 0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin errors++; $display("FAIL rdrop_restart: got req %b addr %h want 1 0", imem_req, imem_addr); end
    exp_q.push_back(mk(32'd0));
    inst_ready = 1'b1;
    cycle();
    cycle();
    inst_ready = 1'b0;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rdrop_drain: got %0d pending want 0", exp_q.size()); end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    mem_wait    = 0;
    wait_cnt    = 0;
    imem_rdata  = 32'd0;
    imem_rdata2 = 32'd0;
    imem_ack2   = 1'b0;
    redirect2   = 1'b0;
    next_pc2    = 32'd0;
    inst_ready2 = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_drop();
    test_redirect_ack();
    test_full_redirect();
    test_wrap();
    test_reset_in_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
